// File: rtl/iic_arbiter_if.sv
// iic_arbiter_if: bundles the two requester ports, the shared read-data
// return path, status outputs and the iic_ctrl master-side signals.
//   slave  modport: the arbiter (drives ack/err/rdata/grant/busy/iic_* out)
//   master modport: the surroundings (requesters + iic_ctrl)
interface iic_arbiter_if;
  logic        req0, op0, ack0, err0;
  logic [15:0] addr0;
  logic [7:0]  wdata0;
  logic        req1, op1, ack1, err1;
  logic [15:0] addr1;
  logic [7:0]  wdata1;
  logic [7:0]  rdata;
  logic        rvalid;
  logic [1:0]  grant;
  logic        busy;
  logic        iic_wr_en, iic_rd_en;
  logic [15:0] iic_addr;
  logic [7:0]  iic_data;
  logic        iic_done;
  logic [7:0]  iic_rd_data;

  modport slave (
    input  req0, op0, addr0, wdata0, req1, op1, addr1, wdata1,
           iic_done, iic_rd_data,
    output ack0, err0, ack1, err1, rdata, rvalid, grant, busy,
           iic_wr_en, iic_rd_en, iic_addr, iic_data
  );

  modport master (
    output req0, op0, addr0, wdata0, req1, op1, addr1, wdata1,
           iic_done, iic_rd_data,
    input  ack0, err0, ack1, err1, rdata, rvalid, grant, busy,
           iic_wr_en, iic_rd_en, iic_addr, iic_data
  );
endinterface

// File: rtl/iic_arbiter.sv
// iic_arbiter: round-robin share of one iic_ctrl EEPROM master between two
// requesters. Latches the winner's op/addr/data, pulses wr_en or rd_en for
// one cycle, waits for done, returns ack (+rdata/rvalid for reads), then
// holds off new work for the EEPROM write-cycle gap after a write.
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-high reset
//   bus (slave)  req/op/addr/wdata/ack/err per requester, rdata/rvalid,
//                grant (one-hot owner), busy, iic_wr_en/rd_en/addr/data to
//                iic_ctrl, iic_done/iic_rd_data from iic_ctrl
//
// Optional feature macro: IIC_ARB_TIMEOUT_EN
//   defined   -> WAIT gives up after TIMEOUT_CYCLES without done, pulses errN
//   undefined -> WAIT lasts until done, err0/err1 stay 0
module iic_arbiter #(
  parameter int GAP_CYCLES     = 250000,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic         clk,
  input  logic         rst,
  iic_arbiter_if.slave bus
);

  // Counters only ever hold (N-1) down/up to 0, so $clog2(N) bits suffice.
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
`ifdef IIC_ARB_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
`endif

  if (GAP_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_chk
    $error("iic_arbiter: GAP_CYCLES and TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP} state_t;

  // Requester inputs packed by index so selection is a single mux.
  logic [1:0]       req, op_in;
  logic [1:0][15:0] addr_in;
  logic [1:0][7:0]  wdata_in;

  assign req      = {bus.req1, bus.req0};
  assign op_in    = {bus.op1, bus.op0};
  assign addr_in  = {bus.addr1, bus.addr0};
  assign wdata_in = {bus.wdata1, bus.wdata0};

  state_t          state_q, state_d;
  logic            last_q, last_d;     // last granted index, also current owner
  logic            op_q, op_d;
  logic [1:0]      grant_q, grant_d;
  logic [15:0]     addr_q, addr_d;
  logic [7:0]      data_q, data_d;
  logic            wr_en_q, wr_en_d;
  logic            rd_en_q, rd_en_d;
  logic [1:0]      ack_q, ack_d;
  logic [1:0]      err_q, err_d;
  logic [7:0]      rdata_q, rdata_d;
  logic            rvalid_q, rvalid_d;
  logic            busy_q, busy_d;
  logic [GW-1:0]   gap_q, gap_d;
`ifdef IIC_ARB_TIMEOUT_EN
  logic [TW-1:0]   tmo_q, tmo_d;
`endif
  logic            sel;

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    op_d     = op_q;
    grant_d  = grant_q;
    addr_d   = addr_q;
    data_d   = data_q;
    wr_en_d  = 1'b0;
    rd_en_d  = 1'b0;
    ack_d    = '0;
    err_d    = '0;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    gap_d    = gap_q;
`ifdef IIC_ARB_TIMEOUT_EN
    tmo_d    = tmo_q;
`endif
    sel      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (|req) begin
          // Under contention the requester not served last wins.
          sel     = (req == 2'b11) ? ~last_q : req[1];
          state_d = S_ISSUE;
          last_d  = sel;
          op_d    = op_in[sel];
          addr_d  = addr_in[sel];
          data_d  = wdata_in[sel];
          grant_d = sel ? 2'b10 : 2'b01;
          // Enables are registered, so they are high during ISSUE only.
          wr_en_d = ~op_in[sel];
          rd_en_d = op_in[sel];
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
`ifdef IIC_ARB_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end
      S_WAIT: begin
        if (bus.iic_done) begin
          state_d       = S_GAP;
          grant_d       = '0;
          ack_d[last_q] = 1'b1;
          if (op_q) begin
            rdata_d  = bus.iic_rd_data;
            rvalid_d = 1'b1;
            gap_d    = '0;
          end else begin
            gap_d    = GW'(GAP_CYCLES - 1);
          end
        end
`ifdef IIC_ARB_TIMEOUT_EN
        else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          // A stuck bus may have left a write half done: always take the
          // full write-cycle gap.
          state_d       = S_GAP;
          grant_d       = '0;
          err_d[last_q] = 1'b1;
          gap_d         = GW'(GAP_CYCLES - 1);
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      S_GAP: begin
        if (gap_q == '0) state_d = S_IDLE;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      last_q   <= 1'b1;
      op_q     <= 1'b0;
      grant_q  <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      wr_en_q  <= 1'b0;
      rd_en_q  <= 1'b0;
      ack_q    <= '0;
      err_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      gap_q    <= '0;
`ifdef IIC_ARB_TIMEOUT_EN
      tmo_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      op_q     <= op_d;
      grant_q  <= grant_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      wr_en_q  <= wr_en_d;
      rd_en_q  <= rd_en_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      busy_q   <= busy_d;
      gap_q    <= gap_d;
`ifdef IIC_ARB_TIMEOUT_EN
      tmo_q    <= tmo_d;
`endif
    end
  end

  assign bus.ack0      = ack_q[0];
  assign bus.ack1      = ack_q[1];
  assign bus.err0      = err_q[0];
  assign bus.err1      = err_q[1];
  assign bus.rdata     = rdata_q;
  assign bus.rvalid    = rvalid_q;
  assign bus.grant     = grant_q;
  assign bus.busy      = busy_q;
  assign bus.iic_wr_en = wr_en_q;
  assign bus.iic_rd_en = rd_en_q;
  assign bus.iic_addr  = addr_q;
  assign bus.iic_data  = data_q;

endmodule

// File: tb/tb_iic_arbiter.sv
`timescale 1ns/1ps
module tb_iic_arbiter;
  localparam int GAP = 12;
  localparam int TMO = 100;
  localparam int NTX = 30;
  localparam int BOUND = 3000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  iic_arbiter_if bus();

  iic_arbiter #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // EEPROM read contents as seen by the model: a fixed function of address.
  function automatic logic [7:0] rom(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  function automatic logic [9:0] outs();
    return {bus.ack0, bus.ack1, bus.err0, bus.err1, bus.rvalid, bus.busy,
            bus.iic_wr_en, bus.iic_rd_en, bus.grant};
  endfunction

  typedef struct { logic op; logic [15:0] addr; logic [7:0] data; logic [7:0] rd; } txn_t;
  txn_t expq0[$], expq1[$];

  task automatic set_req(input int n, input logic r, input logic op,
                         input logic [15:0] a, input logic [7:0] d);
    if (n == 0) begin bus.req0 = r; bus.op0 = op; bus.addr0 = a; bus.wdata0 = d; end
    else        begin bus.req1 = r; bus.op1 = op; bus.addr1 = a; bus.wdata1 = d; end
  endtask

  // ---------------- EEPROM / iic_ctrl model ----------------
  logic mute = 1'b0;
  initial begin
    bus.iic_done = 1'b0;
    bus.iic_rd_data = 8'h00;
    forever begin
      @(negedge clk);
      if ((bus.iic_wr_en || bus.iic_rd_en) && !mute && !rst) begin
        logic rd; logic [15:0] a;
        rd = bus.iic_rd_en; a = bus.iic_addr;
        repeat ($urandom_range(1, 5)) @(posedge clk);
        #1 bus.iic_done = 1'b1;
        bus.iic_rd_data = rd ? rom(a) : 8'($urandom);
        @(posedge clk); #1 bus.iic_done = 1'b0;
        bus.iic_rd_data = 8'($urandom);
        if ($urandom_range(0, 2) == 0) begin
          // stray done while not in WAIT: must be ignored
          @(posedge clk); #1 bus.iic_done = 1'b1;
          @(posedge clk); #1 bus.iic_done = 1'b0;
        end
      end
    end
  end

  // ---------------- requesters (stimulus + expectation push) ----------------
  task automatic requester(input int n, input int count);
    for (int k = 0; k < count; k++) begin
      txn_t t;
      int g;
      t.op = 1'($urandom_range(0, 1));
      t.addr = 16'($urandom);
      t.data = 8'($urandom);
      t.rd = rom(t.addr);
      if (n == 0) expq0.push_back(t); else expq1.push_back(t);
      set_req(n, 1'b1, t.op, t.addr, t.data);
      g = 0;
      do begin @(negedge clk); g++; end
      while (!((bus.iic_wr_en || bus.iic_rd_en) && bus.grant[n]) && g < BOUND);
      if (g >= BOUND) begin chk("req_grant_timeout", 0, 1); return; end
      // inputs are free to change after selection; sometimes drop req
      @(posedge clk); #1;
      set_req(n, ($urandom_range(0, 3) != 0), 1'($urandom), 16'($urandom), 8'($urandom));
      g = 0;
      do begin @(negedge clk); g++; end
      while (!(n == 0 ? bus.ack0 : bus.ack1) && g < BOUND);
      if (g >= BOUND) begin chk("req_ack_timeout", 0, 1); return; end
      @(posedge clk); #1;
      set_req(n, 1'b0, 1'b0, 16'h0, 8'h0);
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic mon_en = 1'b0;
  initial begin
    logic [1:0] prev_req = 2'b00, ackv;
    logic last_own = 1'b1, own = 1'b0, in_txn = 1'b0;
    logic [7:0] last_rd = 8'h00;
    int exp_issue = -1, exp_ack = -1, idle_from = 0, busy_hi = -1, issue_cyc = 0;
    txn_t cur;
    cur = '{op: 1'b0, addr: 16'h0, data: 8'h0, rd: 8'h0};
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (bus.iic_wr_en || bus.iic_rd_en) begin
          if (in_txn || exp_issue < 0) chk("spurious_issue", 1, 0);
          else begin
            chk("issue_time", cyc, exp_issue);
            own = (prev_req == 2'b11) ? !last_own : prev_req[1];
            last_own = own;
            if ((own ? expq1.size() : expq0.size()) == 0) chk("issue_no_req", 1, 0);
            else cur = own ? expq1.pop_front() : expq0.pop_front();
            chk("grant", bus.grant, own ? 2'b10 : 2'b01);
            chk("issue_op", {bus.iic_wr_en, bus.iic_rd_en}, cur.op ? 2'b01 : 2'b10);
            chk("issue_addr", bus.iic_addr, cur.addr);
            if (!cur.op) chk("issue_data", bus.iic_data, cur.data);
            chk("rdata_hold", bus.rdata, last_rd);
            chk("busy_issue", bus.busy, 1);
            in_txn = 1'b1; issue_cyc = cyc; exp_issue = -1;
          end
        end else if (exp_issue >= 0 && cyc >= exp_issue) begin
          chk("missing_issue", 0, 1);
          exp_issue = -1;
        end

        if (in_txn && bus.iic_done && exp_ack < 0 && cyc > issue_cyc) begin
          exp_ack = cyc + 1;
          chk("addr_stable", bus.iic_addr, cur.addr);
        end

        ackv = {bus.ack1, bus.ack0};
        if (exp_ack >= 0 && cyc == exp_ack) begin
          chk("ack", ackv, own ? 2'b10 : 2'b01);
          chk("rvalid", bus.rvalid, cur.op);
          if (cur.op) begin chk("rdata", bus.rdata, cur.rd); last_rd = cur.rd; end
          chk("grant_clear", bus.grant, 0);
          idle_from = cyc + (cur.op ? 1 : GAP);
          busy_hi = idle_from - 1;
          in_txn = 1'b0; exp_ack = -1;
        end else if (ackv != 2'b00 || bus.rvalid) begin
          chk("spurious_ack", {bus.rvalid, ackv}, 0);
        end
        if (bus.err0 || bus.err1) chk("spurious_err", {bus.err1, bus.err0}, 0);
        if (cyc == busy_hi)   chk("busy_gap", bus.busy, 1);
        if (cyc == idle_from) chk("busy_idle", bus.busy, 0);

        if (!in_txn && cyc >= idle_from && exp_issue < 0 && {bus.req1, bus.req0} != 2'b00)
          exp_issue = cyc + 1;
        prev_req = {bus.req1, bus.req0};
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int g, i, e;
    set_req(0, 1'b0, 1'b0, 16'h0, 8'h0);
    set_req(1, 1'b0, 1'b0, 16'h0, 8'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", outs(), 0);
    chk("reset_bus", {bus.iic_addr, bus.iic_data, bus.rdata}, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_outs", outs(), 0);

    // Random phase: both requesters start together (contention from reset).
    @(posedge clk); #1;
    mon_en = 1'b1;
    fork
      requester(0, NTX);
      requester(1, NTX);
    join
    repeat (GAP + 10) @(posedge clk);
    mon_en = 1'b0;
    chk("q0_drained", expq0.size(), 0);
    chk("q1_drained", expq1.size(), 0);

    // Reset during WAIT: transaction discarded, outputs clear immediately.
    #1 mute = 1'b1;
    set_req(0, 1'b1, 1'b0, 16'h005A, 8'd107);
    g = 0;
    do begin @(negedge clk); g++; end while (!bus.iic_wr_en && g < BOUND);
    chk("dir_wr_issue", {bus.iic_wr_en, bus.iic_addr, bus.iic_data}, {1'b1, 16'h005A, 8'h6B});
    @(posedge clk); #1 set_req(0, 1'b0, 1'b0, 16'h0, 8'h0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_wait_outs", outs(), 0);
    chk("rst_wait_bus", {bus.iic_addr, bus.iic_data, bus.rdata}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) begin @(negedge clk); chk("rst_no_ack", outs(), 0); end

    // Pointer back at reset value: requester 0 wins contention.
    mute = 1'b0;
    @(posedge clk); #1;
    set_req(0, 1'b1, 1'b1, 16'h005B, 8'h00);
    set_req(1, 1'b1, 1'b0, 16'h0100, 8'h11);
    g = 0;
    do begin @(negedge clk); g++; end while (!(bus.iic_wr_en || bus.iic_rd_en) && g < BOUND);
    chk("post_rst_grant", {bus.grant, bus.iic_rd_en}, {2'b01, 1'b1});
    @(posedge clk); #1 set_req(1, 1'b0, 1'b0, 16'h0, 8'h0);
    g = 0;
    do begin @(negedge clk); g++; end while (!bus.ack0 && g < BOUND);
    chk("post_rst_read", {bus.ack0, bus.rvalid, bus.rdata}, {1'b1, 1'b1, rom(16'h005B)});
    @(posedge clk); #1 set_req(0, 1'b0, 1'b0, 16'h0, 8'h0);
    repeat (GAP + 4) @(posedge clk);

`ifdef IIC_ARB_TIMEOUT_EN
    // Timeout: done never arrives; err0 after TMO WAIT cycles, late done ignored.
    #1 mute = 1'b1;
    set_req(0, 1'b1, 1'b0, 16'h0077, 8'h55);
    g = 0;
    do begin @(negedge clk); g++; end while (!bus.iic_wr_en && g < BOUND);
    i = cyc;
    @(posedge clk); #1;
    set_req(0, 1'b0, 1'b0, 16'h0, 8'h0);
    set_req(1, 1'b1, 1'b1, 16'h1234, 8'h00);
    g = 0;
    do begin
      @(negedge clk); g++;
      if (bus.ack0) chk("to_no_ack", 1, 0);
    end while (!bus.err0 && g < BOUND);
    e = cyc;
    chk("to_err_time", e, i + 1 + TMO);
    chk("to_err_outs", {bus.ack0, bus.rvalid, bus.grant}, 0);
    @(posedge clk); #1 bus.iic_done = 1'b1;
    @(posedge clk); #1 bus.iic_done = 1'b0;
    mute = 1'b0;
    @(negedge clk);
    chk("late_done_ignored", {bus.ack0, bus.ack1, bus.rvalid}, 0);
    g = 0;
    do begin @(negedge clk); g++; end while (!bus.iic_rd_en && g < BOUND);
    chk("to_next_issue", cyc, e + GAP + 1);
    chk("to_next_grant", bus.grant, 2'b10);
    @(posedge clk); #1 set_req(1, 1'b0, 1'b0, 16'h0, 8'h0);
    g = 0;
    do begin @(negedge clk); g++; end while (!bus.ack1 && g < BOUND);
    chk("to_next_read", {bus.ack1, bus.rvalid, bus.rdata}, {1'b1, 1'b1, rom(16'h1234)});
    repeat (4) @(posedge clk);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
